cmd_issuer: RTL
===============

// Module: cmd_issuer
// PURPOSE
// Pops commands from the show-ahead command queue, checks address hazards against commands in flight,
// and dispatches each command to a free SIMD core over a valid/ready handshake.
// Sits between the command queue and the core array inside top; drives the queue pop strobe issuer_rd_queue.
// Keeps a per-core scoreboard of in-flight src/dst addresses and stalls the pipe on any dependency.
// PARAMETERS
// NUM_CORES  4   number of SIMD cores served
// ADDR_W     20  shared-memory address field width
// OP_W       4   opcode field width
// CMD_W      OP_W+3*ADDR_W (localparam); fields: [CMD_W-1-:OP_W] op, dst, src0, src1 (MSB to LSB)
// OP_BARRIER 4'hF  opcode that waits for all cores idle; never dispatched
// PORTS
// i_clk            in   1          clock
// i_rstn           in   1          async active-low reset
// queue_cmd        in   CMD_W      head of command queue; valid whenever queue_empty=0
// queue_empty      in   1          queue has no entry
// issuer_rd_queue  out  1          1-cycle pop strobe; head consumed at this edge
// o_core_valid     out  NUM_CORES  one-hot dispatch request
// o_core_cmd       out  CMD_W      command bus shared by all cores
// i_core_ready     in   NUM_CORES  core accepts o_core_cmd
// i_core_done      in   NUM_CORES  1-cycle pulse: core finished its command
// o_stall_dep      out  1          held command blocked by hazard or barrier
// o_idle           out  1          no held command and all cores free
// BEHAVIOUR
// - Clock is i_clk; reset is asynchronous, active-low on i_rstn.
// - Reset (async, any state): FSM=S_EMPTY, busy=0, scoreboard cleared, issuer_rd_queue=0, o_core_valid=0,
//   o_core_cmd=0, o_stall_dep=0, o_idle=1. Reset mid-dispatch drops valid immediately; held cmd is lost.
// - FSM S_EMPTY: if !queue_empty -> issuer_rd_queue=1 (combinational, this cycle), latch queue_cmd, -> S_HELD.
//   Never pop while a command is held: at most one held command.
// - S_HELD: hazard = for any busy core k: new.src0/src1/dst == sb_dst[k] (RAW/WAW) or
//   new.dst == sb_src0[k]/sb_src1[k] (WAR). Compare uses registered scoreboard only.
//   op==OP_BARRIER: stall until busy==0, then drop command, -> S_EMPTY (no dispatch).
//   hazard: stay, o_stall_dep=1. No hazard and no free core: stay, o_stall_dep=0.
//   No hazard, free core: choose core sel (see CONFIGURATION), -> S_DISPATCH.
// - S_DISPATCH: o_core_valid[sel]=1, o_core_cmd=held cmd, both stable until i_core_ready[sel]=1.
//   On ready edge: busy[sel]<=1, sb[sel]<={dst,src0,src1}, -> S_EMPTY. Min issue rate 1 cmd / 3 cycles.
// - i_core_done[k] clears busy[k] at the edge; effect on hazard/free checks visible next cycle.
//   done on an idle core ignored. done[k] and accept on same k cannot coincide (sel only free cores).
// - ready on a non-selected core ignored. o_core_cmd=0 when no valid asserted.
// - o_idle = (state==S_EMPTY) && busy==0, registered-free combinational decode.
// CONFIGURATION
// ISSUER_RR_ARB_EN defined: round-robin core select; pointer starts at 0, after dispatch to sel
//   search restarts at sel+1 mod NUM_CORES.
// Not defined: fixed priority, lowest-index free core.
// TESTING
// 1 Reset: i_rstn=0 with queue full -> all outputs at reset values, no pop; release -> pop on 1st clock.
// 2 Independent: 4 cmds dst 0x10..0x13, srcs 0x100+, ready=1 -> cores 0,1,2,3 each get one cmd, 4 pops.
// 3 RAW: cmd A dst=0x20 on core0, cmd B src0=0x20 -> o_stall_dep=1 until done[0];
//   B dispatched to core0 (fixed prio) / core1 (RR) 2 cycles after done.
// 4 Barrier: 2 busy cores, OP_BARRIER -> no dispatch, stall until both done, popped, never on core bus.
// 5 All busy, no hazard: 5th cmd waits with o_stall_dep=0; done[2] -> dispatched to core2.
// 6 Backpressure: ready held 0 for 5 cycles -> valid/cmd stable, no further pop; async reset mid-wait drops valid.

Source files
------------

// File: rtl/cmd_issuer_if.sv
// Handshake bundle between cmd_issuer, the command queue and the SIMD core array.
// master = issuer side, slave = queue/core side.
interface cmd_issuer_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned CMD_W     = 64
);
    logic [CMD_W-1:0]     queue_cmd;
    logic                 queue_empty;
    logic                 issuer_rd_queue;
    logic [NUM_CORES-1:0] o_core_valid;
    logic [CMD_W-1:0]     o_core_cmd;
    logic [NUM_CORES-1:0] i_core_ready;
    logic [NUM_CORES-1:0] i_core_done;
    logic                 o_stall_dep;
    logic                 o_idle;

    modport master (
        input  queue_cmd, queue_empty, i_core_ready, i_core_done,
        output issuer_rd_queue, o_core_valid, o_core_cmd, o_stall_dep, o_idle
    );

    modport slave (
        output queue_cmd, queue_empty, i_core_ready, i_core_done,
        input  issuer_rd_queue, o_core_valid, o_core_cmd, o_stall_dep, o_idle
    );
endinterface

// File: rtl/cmd_issuer.sv
// Pops commands from a show-ahead queue, checks address hazards against in-flight commands and
// dispatches to a free core. Define ISSUER_RR_ARB_EN for round-robin core select (else lowest free).
module cmd_issuer #(
    parameter int unsigned     NUM_CORES  = 4,
    parameter int unsigned     ADDR_W     = 20,
    parameter int unsigned     OP_W       = 4,
    parameter logic [OP_W-1:0] OP_BARRIER = {OP_W{1'b1}}
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    cmd_issuer_if.master bus
);
    localparam int unsigned CMD_W = OP_W + 3 * ADDR_W;
    localparam int unsigned SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {StEmpty, StHeld, StDispatch} state_e;

    state_e               state_q, state_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_CORES-1:0] busy_q, busy_d;
    logic [ADDR_W-1:0]    sb_dst_q  [NUM_CORES];
    logic [ADDR_W-1:0]    sb_src0_q [NUM_CORES];
    logic [ADDR_W-1:0]    sb_src1_q [NUM_CORES];

    logic [OP_W-1:0]      op;
    logic [ADDR_W-1:0]    dst, src0, src1;
    logic                 hazard, any_free, accept, pop, stall;
    logic [SEL_W-1:0]     free_sel;
    logic [NUM_CORES-1:0] core_valid;

    assign op   = cmd_q[CMD_W-1 -: OP_W];
    assign dst  = cmd_q[3*ADDR_W-1 -: ADDR_W];
    assign src0 = cmd_q[2*ADDR_W-1 -: ADDR_W];
    assign src1 = cmd_q[ADDR_W-1:0];

    // RAW/WAW against in-flight dst, WAR against in-flight sources.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < int'(NUM_CORES); k++) begin
            if (busy_q[k] && (src0 == sb_dst_q[k] || src1 == sb_dst_q[k] || dst == sb_dst_q[k] ||
                              dst == sb_src0_q[k] || dst == sb_src1_q[k])) begin
                hazard = 1'b1;
            end
        end
    end

`ifdef ISSUER_RR_ARB_EN
    logic [SEL_W-1:0] rr_q, rr_d;

    always_comb begin
        int idx;
        any_free = 1'b0;
        free_sel = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NUM_CORES)) idx = idx - int'(NUM_CORES);
            if (!any_free && !busy_q[idx]) begin
                any_free = 1'b1;
                free_sel = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) rr_d = (int'(sel_q) == int'(NUM_CORES) - 1) ? '0 : sel_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) rr_q <= '0;
        else         rr_q <= rr_d;
    end
`else
    // Descending scan so the lowest free index wins.
    always_comb begin
        any_free = 1'b0;
        free_sel = '0;
        for (int k = int'(NUM_CORES) - 1; k >= 0; k--) begin
            if (!busy_q[k]) begin
                any_free = 1'b1;
                free_sel = SEL_W'(k);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        sel_d      = sel_q;
        busy_d     = busy_q & ~bus.i_core_done;
        accept     = 1'b0;
        pop        = 1'b0;
        stall      = 1'b0;
        core_valid = '0;
        case (state_q)
            StEmpty: begin
                if (!bus.queue_empty) begin
                    pop     = 1'b1;
                    cmd_d   = bus.queue_cmd;
                    state_d = StHeld;
                end
            end
            StHeld: begin
                if (op == OP_BARRIER) begin
                    if (busy_q == '0) state_d = StEmpty;
                    else              stall   = 1'b1;
                end else if (hazard) begin
                    stall = 1'b1;
                end else if (any_free) begin
                    sel_d   = free_sel;
                    state_d = StDispatch;
                end
            end
            StDispatch: begin
                core_valid[sel_q] = 1'b1;
                if (bus.i_core_ready[sel_q]) begin
                    accept        = 1'b1;
                    busy_d[sel_q] = 1'b1;
                    state_d       = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StEmpty;
            cmd_q   <= '0;
            sel_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < int'(NUM_CORES); k++) begin
                sb_dst_q[k]  <= '0;
                sb_src0_q[k] <= '0;
                sb_src1_q[k] <= '0;
            end
        end else if (accept) begin
            sb_dst_q[sel_q]  <= dst;
            sb_src0_q[sel_q] <= src0;
            sb_src1_q[sel_q] <= src1;
        end
    end

    // Pop is masked during reset so a full queue is never consumed while held in reset.
    assign bus.issuer_rd_queue = pop & i_rstn;
    assign bus.o_core_valid    = core_valid;
    assign bus.o_core_cmd      = (state_q == StDispatch) ? cmd_q : '0;
    assign bus.o_stall_dep     = stall;
    assign bus.o_idle          = (state_q == StEmpty) && (busy_q == '0);
endmodule
